// File: rtl/stack_cmd_sequencer.sv
// Host-side command sequencer for the stack core: command FIFO, depth tracking, strobe/done issue.
// Optional WAIT abort on a stuck core when STACK_SEQ_TIMEOUT_EN is defined.
module stack_cmd_sequencer #(
    parameter int DATA_W     = 8,
    parameter int STK_DEPTH  = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_err,
    output logic              stk_push,
    output logic              stk_pop,
    output logic [DATA_W-1:0] stk_wdata,
    input  logic [DATA_W-1:0] stk_rdata,
    input  logic              stk_done,
    output logic [5:0]        depth
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, RESP} state_t;
    typedef struct packed {
        logic              op;
        logic [DATA_W-1:0] data;
    } cmd_t;

    state_t            state, state_nxt;
    cmd_t              fifo_mem [FIFO_DEPTH];
    cmd_t              head, cur;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic              fifo_empty, fifo_full, cmd_fire;
    logic              take, fifo_wr, fifo_rd;
    logic [1:0]        chk_err;
    logic              first_wait, wait_exit, timed_out;
`ifdef STACK_SEQ_TIMEOUT_EN
    logic [3:0]        wait_cnt;
`endif

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign cmd_ready  = !fifo_full;
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign rsp_valid  = (state == RESP);

    // An empty FIFO falls through: the incoming command goes straight to CHECK.
    assign take    = (state == IDLE) && (!fifo_empty || cmd_fire);
    assign fifo_rd = take && !fifo_empty;
    assign fifo_wr = cmd_fire && !(take && fifo_empty);
    assign head    = fifo_empty ? cmd_t'({cmd_op, cmd_data}) : fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (fifo_wr)
            fifo_mem[wr_ptr] <= {cmd_op, cmd_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PTR_W{1'b0}}, fifo_wr} - {{PTR_W{1'b0}}, fifo_rd};
        end
    end

    always_comb begin
        chk_err = 2'b00;
        if (!cur.op && depth == 6'(STK_DEPTH)) chk_err = 2'b01;
        else if (cur.op && depth == 6'd0)      chk_err = 2'b10;
    end

    always_comb begin
        state_nxt = state;
        wait_exit = 1'b0;
        timed_out = 1'b0;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        case (state)
            IDLE:  if (take) state_nxt = CHECK;
            CHECK: state_nxt = (chk_err != 2'b00) ? RESP : ISSUE;
            ISSUE: begin
                stk_push  = !cur.op;
                stk_pop   = cur.op;
                state_nxt = WAIT;
            end
            WAIT: begin
                // done may still be high from the previous instruction on the first cycle
                if (!first_wait && stk_done) begin
                    wait_exit = 1'b1;
                    state_nxt = RESP;
                end
`ifdef STACK_SEQ_TIMEOUT_EN
                else if (wait_cnt == 4'(TIMEOUT - 1)) begin
                    timed_out = 1'b1;
                    state_nxt = RESP;
                end
`endif
            end
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur        <= '0;
            depth      <= '0;
            rsp_data   <= '0;
            rsp_err    <= 2'b00;
            stk_wdata  <= '0;
            first_wait <= 1'b0;
`ifdef STACK_SEQ_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (take) cur <= head;
            if (state == CHECK) begin
                rsp_err  <= chk_err;
                rsp_data <= '0;
                if (chk_err == 2'b00) stk_wdata <= cur.op ? '0 : cur.data;
            end
            if (state == ISSUE) first_wait <= 1'b1;
            if (state == WAIT)  first_wait <= 1'b0;
`ifdef STACK_SEQ_TIMEOUT_EN
            if (state == ISSUE) wait_cnt <= '0;
            if (state == WAIT)  wait_cnt <= wait_cnt + 4'd1;
`endif
            if (wait_exit) begin
                rsp_err <= 2'b00;
                if (cur.op) begin
                    depth    <= depth - 6'd1;
                    rsp_data <= stk_rdata;
                end else begin
                    depth    <= depth + 6'd1;
                    rsp_data <= '0;
                end
            end
            if (timed_out) begin
                rsp_err  <= 2'b11;
                rsp_data <= '0;
            end
        end
    end
endmodule

// File: tb/tb_stack_cmd_sequencer.sv
// Directed bench for stack_cmd_sequencer with a behavioural 32x8 stack core model.
module tb_stack_cmd_sequencer;
    logic       clk, rst;
    logic       cmd_valid, cmd_ready, cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic [1:0] rsp_err;
    logic       stk_push, stk_pop, stk_done;
    logic [7:0] stk_wdata, stk_rdata;
    logic [5:0] depth;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    stack_cmd_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_wdata(stk_wdata), .stk_rdata(stk_rdata),
        .stk_done(stk_done), .depth(depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // core model: done drops for core_lat cycles after a strobe; hold_low parks it low
    logic [7:0] smem [0:63];
    int sp, busy, core_lat;
    bit hold_low;
    int push_cnt, pop_cnt, dual_cnt, max_depth;

    always @(posedge clk) begin
        if (rst) begin
            sp <= 0; busy <= 0; stk_done <= 1'b1; stk_rdata <= 8'h00;
        end else if (stk_push || stk_pop) begin
            if (stk_push) begin smem[sp] <= stk_wdata; sp <= sp + 1; end
            else if (sp > 0) begin stk_rdata <= smem[sp-1]; sp <= sp - 1; end
            if (core_lat > 0 || hold_low) begin stk_done <= 1'b0; busy <= core_lat; end
        end else if (busy > 1) busy <= busy - 1;
        else if (!hold_low) stk_done <= 1'b1;
    end

    always @(posedge clk) begin
        if (stk_push) push_cnt <= push_cnt + 1;
        if (stk_pop)  pop_cnt  <= pop_cnt + 1;
        if (stk_push && stk_pop) dual_cnt <= dual_cnt + 1;
        if (int'(depth) > max_depth) max_depth <= int'(depth);
    end

    typedef struct {
        string      name;
        logic       op;
        logic [7:0] data;
        logic [1:0] err;
        logic [7:0] rdata;
        logic [5:0] depth;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // called at a negedge; returns at the negedge after the accepting posedge
    task automatic send_cmd(input logic op, input logic [7:0] d);
        int n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        if (n >= 100) check("cmd_accept_timeout", 1, 0);
    endtask

    task automatic get_rsp(output logic [1:0] e, output logic [7:0] d);
        int n = 0;
        rsp_ready = 1'b1;
        while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
        e = rsp_err; d = rsp_data;
        if (n >= 200) check("rsp_timeout", 1, 0);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic do_vec(input string nm, input logic op, input logic [7:0] d,
                          input logic [1:0] xe, input logic [7:0] xd, input logic [5:0] xdep);
        logic [1:0] e;
        logic [7:0] r;
        send_cmd(op, d);
        get_rsp(e, r);
        check({nm, "_err"},   32'(e), 32'(xe));
        check({nm, "_data"},  32'(r), 32'(xd));
        check({nm, "_depth"}, 32'(depth), 32'(xdep));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [1:0] e;
        logic [7:0] r;
        int n, s0;
        tbl[0] = '{"t2_pop_empty", 1'b1, 8'h00, 2'b10, 8'h00, 6'd0};
        tbl[1] = '{"t1_push_a5",   1'b0, 8'hA5, 2'b00, 8'h00, 6'd1};
        tbl[2] = '{"t1_pop_a5",    1'b1, 8'h00, 2'b00, 8'hA5, 6'd0};
        tbl[3] = '{"push_3c",      1'b0, 8'h3C, 2'b00, 8'h00, 6'd1};
        tbl[4] = '{"push_77",      1'b0, 8'h77, 2'b00, 8'h00, 6'd2};
        tbl[5] = '{"pop_77",       1'b1, 8'h00, 2'b00, 8'h77, 6'd1};
        tbl[6] = '{"pop_3c",       1'b1, 8'h00, 2'b00, 8'h3C, 6'd0};
        tbl[7] = '{"pop_empty2",   1'b1, 8'h00, 2'b10, 8'h00, 6'd0};

        push_cnt = 0; pop_cnt = 0; dual_cnt = 0; max_depth = 0;
        core_lat = 2; hold_low = 1'b0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_data = 8'h00; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_data",  32'(rsp_data), 0);
        check("rst_rsp_err",   32'(rsp_err), 0);
        check("rst_strobes",   32'({stk_push, stk_pop}), 0);
        check("rst_wdata",     32'(stk_wdata), 0);
        check("rst_depth",     32'(depth), 0);

        for (int i = 0; i < 8; i++) begin
            core_lat = i % 3;
            do_vec(tbl[i].name, tbl[i].op, tbl[i].data, tbl[i].err, tbl[i].rdata, tbl[i].depth);
            if (i == 0) check("t2_no_pop_strobe", 32'(pop_cnt), 0);
        end

        // strobe two cycles after acceptance, no response before the done check
        core_lat = 0;
        send_cmd(1'b0, 8'h42);
        check("lat_n1_no_strobe", 32'(stk_push), 0);
        @(negedge clk);
        check("lat_n2_strobe", 32'(stk_push), 1);
        check("lat_n2_wdata",  32'(stk_wdata), 32'h42);
        @(negedge clk);
        check("lat_n3_no_rsp", 32'(rsp_valid), 0);
        get_rsp(e, r);
        check("lat_err", 32'(e), 0);
        check("lat_depth", 32'(depth), 1);
        do_vec("lat_pop", 1'b1, 8'h00, 2'b00, 8'h42, 6'd0);

        // T3: fill, overflow, drain in LIFO order
        core_lat = 1;
        for (int i = 0; i < 32; i++)
            do_vec("t3_push", 1'b0, 8'(i), 2'b00, 8'h00, 6'(i + 1));
        s0 = push_cnt;
        do_vec("t3_overflow", 1'b0, 8'hFF, 2'b01, 8'h00, 6'd32);
        check("t3_ovf_no_strobe", 32'(push_cnt), 32'(s0));
        for (int i = 0; i < 32; i++)
            do_vec("t3_pop", 1'b1, 8'h00, 2'b00, 8'(31 - i), 6'(31 - i));

        // T4: response held, FIFO fills behind it
        rsp_ready = 1'b0;
        send_cmd(1'b0, 8'h11);
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        check("t4_first_rsp_wait", 32'(n >= 50), 0);
        s0 = push_cnt + pop_cnt;
        for (int k = 0; k < 4; k++) send_cmd(1'b0, 8'(8'h20 + k));
        check("t4_full_not_ready", 32'(cmd_ready), 0);
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_data = 8'h99;
        repeat (4) @(negedge clk);
        check("t4_fifth_blocked", 32'(cmd_ready), 0);
        cmd_valid = 1'b0;
        check("t4_no_strobe", 32'(push_cnt + pop_cnt), 32'(s0));
        for (int k = 0; k < 5; k++) begin
            get_rsp(e, r);
            check("t4_rsp_err", 32'(e), 0);
            check("t4_rsp_depth", 32'(depth), 32'(k + 1));
        end
        do_vec("t4_pop_last", 1'b1, 8'h00, 2'b00, 8'h23, 6'd4);

        // T5: reset while a push waits on the core
        core_lat = 6;
        send_cmd(1'b0, 8'h55);
        n = 0;
        while (!stk_push && n < 20) begin @(negedge clk); n++; end
        check("t5_strobe_seen", 32'(n >= 20), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_depth", 32'(depth), 0);
        check("t5_rsp_valid", 32'(rsp_valid), 0);
        check("t5_fifo_empty", 32'(cmd_ready), 1);
        repeat (8) @(negedge clk);
        check("t5_no_late_rsp", 32'(rsp_valid), 0);
        core_lat = 2;
        do_vec("t5_pop_after_rst", 1'b1, 8'h00, 2'b10, 8'h00, 6'd0);

`ifdef STACK_SEQ_TIMEOUT_EN
        hold_low = 1'b1;
        do_vec("t6_timeout", 1'b0, 8'h66, 2'b11, 8'h00, 6'd0);
        hold_low = 1'b0;
`endif

        check("never_dual_strobe", 32'(dual_cnt), 0);
        check("depth_bound", 32'(max_depth <= 32), 1);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
